// File: rtl/bus_term_pkg.sv
// Shared types and helpers for the bus terminal endpoint and its queues.
package bus_term_pkg;

  localparam int unsigned ID_W          = 8;
  localparam logic [ID_W-1:0] BCAST_ID  = 8'hFF;
  localparam int unsigned MAX_PKT_W     = 64;
  localparam int unsigned DEPTH_DEFAULT = 8;

  typedef logic [$clog2(DEPTH_DEFAULT):0] occ_t;

  // Destination ID sits in the top ID_W bits of a packet of the given width.
  function automatic logic [ID_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                               input int unsigned width);
    logic [MAX_PKT_W-1:0] shifted;
    shifted = pkt >> (width - ID_W);
    return shifted[ID_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; occupancy counter drives full/empty.
module sync_fifo_fwft #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [width-1:0]       wdata,
  input  logic                   rd,
  output logic [width-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(depth):0] count
);
  import bus_term_pkg::*;

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wptr, rptr;
  logic             wr_en, rd_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(depth));
  // A write into a full queue is legal when the head retires in the same cycle.
  assign rd_en = rd && !empty;
  assign wr_en = wr && (!full || rd);
  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_terminal_endpoint.sv
// Device-side bus terminal: TX queue toward the arbiter, ID-filtered RX queue,
// sticky error flags and a saturating RX drop counter.
module bus_terminal_endpoint
  import bus_term_pkg::*;
#(
  parameter int unsigned     width    = 16,
  parameter int unsigned     depth    = 8,
  parameter logic [ID_W-1:0] term_id  = 8'd0,
  parameter logic [ID_W-1:0] bcast_id = BCAST_ID
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tx_wr,
  input  logic [width-1:0]       tx_data,
  output logic                   tx_full,
  output logic [$clog2(depth):0] tx_count,
  output logic                   pndng,
  output logic [width-1:0]       D_pop,
  input  logic                   pop,
  input  logic                   push,
  input  logic [width-1:0]       D_push,
  input  logic                   rx_rd,
  output logic [width-1:0]       rx_data,
  output logic                   rx_valid,
  output logic [7:0]             rx_drop_cnt,
  output logic                   err_underflow,
  output logic                   err_misroute
);

  logic                   tx_empty, rx_empty, rx_full;
  logic [$clog2(depth):0] rx_count_unused;
  logic [ID_W-1:0]        dest;
  logic                   id_match, accept;

  assign dest     = dest_of(MAX_PKT_W'(D_push), width);
  assign id_match = (dest == term_id) || (dest == bcast_id);
  assign accept   = push && id_match;
  assign pndng    = !tx_empty;
  assign rx_valid = !rx_empty;

  sync_fifo_fwft #(.width(width), .depth(depth)) u_tx (
    .clk   (clk),
    .reset (reset),
    .wr    (tx_wr),
    .wdata (tx_data),
    .rd    (pop),
    .rdata (D_pop),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count)
  );

  sync_fifo_fwft #(.width(width), .depth(depth)) u_rx (
    .clk   (clk),
    .reset (reset),
    .wr    (accept),
    .wdata (D_push),
    .rd    (rx_rd),
    .rdata (rx_data),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      err_underflow <= 1'b0;
      err_misroute  <= 1'b0;
      rx_drop_cnt   <= '0;
    end else begin
      if (pop && tx_empty) err_underflow <= 1'b1;
      if (push && !id_match) err_misroute <= 1'b1;
      if (accept && rx_full && !rx_rd && rx_drop_cnt != 8'hFF)
        rx_drop_cnt <= rx_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_terminal_endpoint.sv
// Directed-vector bench for bus_terminal_endpoint with term_id = 3.
module tb_bus_terminal_endpoint;

  logic        clk = 1'b0;
  logic        reset, tx_wr, pop, push, rx_rd;
  logic [15:0] tx_data, D_push;
  logic        tx_full, pndng, rx_valid, err_underflow, err_misroute;
  logic [3:0]  tx_count;
  logic [15:0] D_pop, rx_data;
  logic [7:0]  rx_drop_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  bus_terminal_endpoint #(.width(16), .depth(8), .term_id(8'd3), .bcast_id(8'hFF)) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_wr         (tx_wr),
    .tx_data       (tx_data),
    .tx_full       (tx_full),
    .tx_count      (tx_count),
    .pndng         (pndng),
    .D_pop         (D_pop),
    .pop           (pop),
    .push          (push),
    .D_push        (D_push),
    .rx_rd         (rx_rd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_drop_cnt   (rx_drop_cnt),
    .err_underflow (err_underflow),
    .err_misroute  (err_misroute)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0; reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pndng"},    32'(pndng), 32'd0);
    chk({tag, ".D_pop"},    32'(D_pop), 32'd0);
    chk({tag, ".tx_count"}, 32'(tx_count), 32'd0);
    chk({tag, ".tx_full"},  32'(tx_full), 32'd0);
    chk({tag, ".rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, ".rx_data"},  32'(rx_data), 32'd0);
    chk({tag, ".drop"},     32'(rx_drop_cnt), 32'd0);
    chk({tag, ".err_uf"},   32'(err_underflow), 32'd0);
    chk({tag, ".err_mr"},   32'(err_misroute), 32'd0);
  endtask

  initial begin
    idle();
    tx_data = '0; D_push = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk_all_zero("reset");

    // single TX entry: visible the cycle after the write
    tx_wr = 1'b1; tx_data = 16'h0305;
    tick(); idle();
    chk("t1.pndng", 32'(pndng), 32'd1);
    chk("t1.D_pop", 32'(D_pop), 32'h0305);
    chk("t1.count", 32'(tx_count), 32'd1);
    pop = 1'b1;
    tick(); idle();
    chk("t1.pndng_after_pop", 32'(pndng), 32'd0);
    chk("t1.count_after_pop", 32'(tx_count), 32'd0);

    // fill TX, overflow write ignored, then write+pop on full wraps pointers
    for (int i = 0; i < 8; i++) begin
      tx_wr = 1'b1; tx_data = 16'h0100 + 16'(i);
      tick();
    end
    idle();
    chk("t2.full", 32'(tx_full), 32'd1);
    chk("t2.count", 32'(tx_count), 32'd8);
    tx_wr = 1'b1; tx_data = 16'hDEAD;
    tick(); idle();
    chk("t2.ovf_count", 32'(tx_count), 32'd8);
    chk("t2.ovf_head", 32'(D_pop), 32'h0100);
    tx_wr = 1'b1; pop = 1'b1; tx_data = 16'h0108;
    tick(); idle();
    chk("t2.wrpop_count", 32'(tx_count), 32'd8);
    chk("t2.wrpop_full", 32'(tx_full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t2.order%0d", i), 32'(D_pop), 32'(16'h0100 + 16'(i)));
      pop = 1'b1;
      tick(); idle();
    end
    chk("t2.drained", 32'(pndng), 32'd0);
    chk("t2.drained_cnt", 32'(tx_count), 32'd0);

    // RX filter: own ID, broadcast, misrouted
    push = 1'b1; D_push = 16'h03AA;
    tick(); idle();
    chk("t3.rx_valid", 32'(rx_valid), 32'd1);
    chk("t3.rx_data", 32'(rx_data), 32'h03AA);
    chk("t3.no_mr", 32'(err_misroute), 32'd0);
    push = 1'b1; D_push = 16'hFF11;
    tick(); idle();
    push = 1'b1; D_push = 16'h0422;
    tick(); idle();
    chk("t3.misroute", 32'(err_misroute), 32'd1);
    rx_rd = 1'b1;
    tick(); idle();
    chk("t3.bcast", 32'(rx_data), 32'hFF11);
    rx_rd = 1'b1;
    tick(); idle();
    chk("t3.empty", 32'(rx_valid), 32'd0);
    chk("t3.data0", 32'(rx_data), 32'd0);

    // RX overflow drops, then push with read on full is stored
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; D_push = 16'h0300 + 16'(i);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; D_push = 16'h03F0 + 16'(i);
      tick();
    end
    idle();
    chk("t4.drop3", 32'(rx_drop_cnt), 32'd3);
    chk("t4.head", 32'(rx_data), 32'h0300);
    push = 1'b1; rx_rd = 1'b1; D_push = 16'h0399;
    tick(); idle();
    chk("t4.drop_still3", 32'(rx_drop_cnt), 32'd3);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t4.order%0d", i), 32'(rx_data),
          (i == 8) ? 32'h0399 : 32'(16'h0300 + 16'(i)));
      rx_rd = 1'b1;
      tick(); idle();
    end
    chk("t4.empty", 32'(rx_valid), 32'd0);
    rx_rd = 1'b1;
    tick(); idle();
    chk("t4.rd_empty_noflag", 32'(err_underflow), 32'd0);

    // TX underflow
    pop = 1'b1;
    tick(); idle();
    chk("t5.underflow", 32'(err_underflow), 32'd1);
    chk("t5.count", 32'(tx_count), 32'd0);
    chk("t5.D_pop", 32'(D_pop), 32'd0);

    // mid-traffic reset, with inputs active during the reset cycle
    for (int i = 0; i < 5; i++) begin
      tx_wr = 1'b1; tx_data = 16'h0500 + 16'(i);
      push = (i < 4); D_push = 16'h0300 + 16'(i);
      tick();
    end
    idle();
    chk("t6.pre_count", 32'(tx_count), 32'd5);
    chk("t6.pre_rx", 32'(rx_valid), 32'd1);
    reset = 1'b1; tx_wr = 1'b1; push = 1'b1; pop = 1'b1; D_push = 16'h0422;
    tick(); idle();
    chk_all_zero("t6.reset");
    tick();
    chk_all_zero("t6.after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
